regfile_write_arbiter: RTL

- Shares the single register-file write port between NREQ requesters, e.g. the writeback stage and a load/debug unit.
- Each requester uses a four-phase req/ack handshake. The arbiter runs a matching four-phase handshake toward the register file (`rf_req`/`rf_ack`).
- Arbitration is round-robin. Exactly one write is in flight at a time.
- Sits between the writeback stage(s) and `AsyncRegisterFile`, in the register-file clock domain.

---
 rtl/regfile_write_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing one register-file write port between NREQ four-phase requesters.
// Optional per-phase handshake timeout is enabled by defining RF_ARB_TIMEOUT_EN.
module regfile_write_arbiter #(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned AW      = 4,
    parameter int unsigned DW      = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    output logic [NREQ-1:0]         ack,
    input  logic [NREQ*AW-1:0]      wr_addr,
    input  logic [NREQ*DW-1:0]      wr_data,
    output logic                    rf_req,
    input  logic                    rf_ack,
    output logic                    rf_we,
    output logic [AW-1:0]           rf_addr,
    output logic [DW-1:0]           rf_data,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic [15:0]             write_count,
    output logic                    err
);
    localparam int unsigned IW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_param_check
        $error("regfile_write_arbiter: NREQ must be 2..8 and TIMEOUT at least 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state;
    logic [IW-1:0]   rr_ptr;
    logic            pick_valid_c;
    logic [IW-1:0]   pick_idx_c;
    logic [IW-1:0]   rr_next_c;
    logic [NREQ-1:0] grant_onehot_c;

    // First asserted request scanning upward from the round-robin start index
    always_comb begin
        int unsigned idx;
        pick_valid_c = 1'b0;
        pick_idx_c   = '0;
        idx          = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(rr_ptr) + k) % NREQ;
            if (!pick_valid_c && req[IW'(idx)]) begin
                pick_valid_c = 1'b1;
                pick_idx_c   = IW'(idx);
            end
        end
    end

    assign rr_next_c      = (32'(grant_id) == NREQ - 1) ? '0 : grant_id + IW'(1);
    assign grant_onehot_c = NREQ'(1) << grant_id;

`ifdef RF_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] phase_cnt;
    logic          rf_ack_low_seen;
    logic          phase_expired_c;

    assign phase_expired_c = (32'(phase_cnt) >= TIMEOUT - 1);
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            ack         <= '0;
            rf_req      <= 1'b0;
            rf_we       <= 1'b0;
            rf_addr     <= '0;
            rf_data     <= '0;
            busy        <= 1'b0;
            grant_id    <= '0;
            write_count <= '0;
`ifdef RF_ARB_TIMEOUT_EN
            err             <= 1'b0;
            phase_cnt       <= '0;
            rf_ack_low_seen <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid_c) begin
                        rf_addr  <= wr_addr[32'(pick_idx_c) * AW +: AW];
                        rf_data  <= wr_data[32'(pick_idx_c) * DW +: DW];
                        grant_id <= pick_idx_c;
                        rf_req   <= 1'b1;
                        rf_we    <= 1'b1;
                        busy     <= 1'b1;
                        state    <= REQ;
`ifdef RF_ARB_TIMEOUT_EN
                        phase_cnt       <= '0;
                        rf_ack_low_seen <= !rf_ack;
`endif
                    end
                end
                REQ: begin
`ifdef RF_ARB_TIMEOUT_EN
                    // A stale rf_ack left high by a timed-out write must drop before it counts
                    if (rf_ack && rf_ack_low_seen) begin
                        rf_req    <= 1'b0;
                        rf_we     <= 1'b0;
                        phase_cnt <= '0;
                        state     <= REL;
                    end else if (phase_expired_c) begin
                        err    <= 1'b1;
                        rf_req <= 1'b0;
                        rf_we  <= 1'b0;
                        ack    <= grant_onehot_c;
                        state  <= DONE;
                    end else begin
                        phase_cnt <= phase_cnt + CW'(1);
                        if (!rf_ack) begin
                            rf_ack_low_seen <= 1'b1;
                        end
                    end
`else
                    if (rf_ack) begin
                        rf_req <= 1'b0;
                        rf_we  <= 1'b0;
                        state  <= REL;
                    end
`endif
                end
                REL: begin
                    if (!rf_ack) begin
                        ack         <= grant_onehot_c;
                        write_count <= write_count + 16'd1;
                        state       <= DONE;
                    end
`ifdef RF_ARB_TIMEOUT_EN
                    else if (phase_expired_c) begin
                        err   <= 1'b1;
                        ack   <= grant_onehot_c;
                        state <= DONE;
                    end else begin
                        phase_cnt <= phase_cnt + CW'(1);
                    end
`endif
                end
                DONE: begin
                    if (!req[grant_id]) begin
                        ack    <= '0;
                        rr_ptr <= rr_next_c;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
